// File: rtl/ch_capture_ctrl.sv
// Channel capture controller: writes synchronized ch_in samples into the channel RAM on each
// sample_en strobe, start..stop, one-shot or looping. Define CAPTURE_TRIG_EN for the edge trigger.
module ch_capture_ctrl #(
  parameter int N_ADDR_BITS = 20,
  parameter int MEM_DEPTH   = 1048576,
  parameter int DATA_WIDTH  = 1
) (
  input  logic                   s_axi_clk,
  input  logic                   s_axi_reset,
  input  logic                   sample_en,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   write_addr,
  input  logic [N_ADDR_BITS-1:0] set_ram_addr,
  input  logic                   write_stop_addr,
  input  logic [N_ADDR_BITS-1:0] stop_addr,
  input  logic                   loop_capture,
  input  logic [DATA_WIDTH-1:0]  ch_in,
`ifdef CAPTURE_TRIG_EN
  input  logic                   trig_pol,
`endif
  output logic [N_ADDR_BITS-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]  ram_din,
  output logic                   wen,
  output logic                   capture_busy,
  output logic                   capture_done,
  output logic                   wrapped,
  output logic [N_ADDR_BITS:0]   sample_count
);

  localparam logic [N_ADDR_BITS-1:0] LAST_ADDR = N_ADDR_BITS'(MEM_DEPTH - 1);
  localparam logic [N_ADDR_BITS-1:0] ADDR_ONE  = {{(N_ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [N_ADDR_BITS:0]   CNT_ONE   = {{N_ADDR_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
`ifdef CAPTURE_TRIG_EN
    , ST_ARMED = 2'd3
`endif
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic [DATA_WIDTH-1:0]   r_ch_meta;
  logic [DATA_WIDTH-1:0]   r_ch_sync;
  logic                    r_arm_q;
  logic                    r_abort_q;
  logic                    r_waddr_q;
  logic                    r_wstop_q;
  logic [N_ADDR_BITS-1:0]  r_start;
  logic [N_ADDR_BITS-1:0]  r_stop;
  logic [N_ADDR_BITS-1:0]  r_ram_addr;
  logic [DATA_WIDTH-1:0]   r_ram_din;
  logic                    r_wen;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_wrapped;
  logic [N_ADDR_BITS:0]    r_count;
`ifdef CAPTURE_TRIG_EN
  logic                    r_last_samp;
  logic                    w_trigger;
`endif

  logic                    w_arm_p;
  logic                    w_abort_p;
  logic                    w_waddr_p;
  logic                    w_wstop_p;
  logic                    w_at_stop;
  logic                    w_final;
  logic [N_ADDR_BITS-1:0]  w_next_addr;
  logic                    w_load_ok;
  logic                    w_start_cap;
  logic                    w_busy_next;

  // GPIO controls are levels; only their rising edges act.
  assign w_arm_p   = arm & ~r_arm_q;
  assign w_abort_p = abort & ~r_abort_q;
  assign w_waddr_p = write_addr & ~r_waddr_q;
  assign w_wstop_p = write_stop_addr & ~r_wstop_q;

  assign w_at_stop   = (r_ram_addr == r_stop);
  assign w_final     = (r_state == ST_CAPTURE) && r_wen && w_at_stop && !loop_capture;
  assign w_next_addr = w_at_stop               ? r_start :
                       (r_ram_addr == LAST_ADDR) ? '0      : r_ram_addr + ADDR_ONE;

`ifdef CAPTURE_TRIG_EN
  assign w_trigger = (r_state == ST_ARMED) && sample_en &&
                     (r_ch_sync[0] == trig_pol) && (r_last_samp != trig_pol);
`endif

  // State register
  always_ff @(posedge s_axi_clk) begin
    if (s_axi_reset) r_state <= ST_IDLE;
    else             r_state <= w_next_state;
  end

  // Next-state logic; abort outranks every other event, including a same-cycle arm.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_next_state = r_state;
    if (w_abort_p) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_arm_p) begin
`ifdef CAPTURE_TRIG_EN
            w_next_state = ST_ARMED;
`else
            w_next_state = ST_CAPTURE;
`endif
          end
        end
`ifdef CAPTURE_TRIG_EN
        ST_ARMED:   if (w_trigger) w_next_state = ST_CAPTURE;
`endif
        ST_CAPTURE: if (w_final)   w_next_state = ST_DONE;
        default:    w_next_state = ST_IDLE;
      endcase
    end
  end

  // Output/decode logic
  always_comb begin
    w_load_ok   = 1'b0;
    w_busy_next = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: w_load_ok = 1'b1;
      default:          w_load_ok = 1'b0;
    endcase
    case (w_next_state)
      ST_CAPTURE: w_busy_next = 1'b1;
`ifdef CAPTURE_TRIG_EN
      ST_ARMED:   w_busy_next = 1'b1;
`endif
      default:    w_busy_next = 1'b0;
    endcase
    w_start_cap = w_load_ok && w_arm_p && !w_abort_p;
  end

  // Datapath: synchronizer, edge history, address/write sequencing and status.
  always_ff @(posedge s_axi_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (s_axi_reset) begin
      r_ch_meta   <= '0;
      r_ch_sync   <= '0;
      r_arm_q     <= 1'b0;
      r_abort_q   <= 1'b0;
      r_waddr_q   <= 1'b0;
      r_wstop_q   <= 1'b0;
      r_start     <= '0;
      r_stop      <= LAST_ADDR;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_wen       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wrapped   <= 1'b0;
      r_count     <= '0;
`ifdef CAPTURE_TRIG_EN
      r_last_samp <= 1'b0;
`endif
    end else begin
      r_ch_meta <= ch_in;
      r_ch_sync <= r_ch_meta;
      r_arm_q   <= arm;
      r_abort_q <= abort;
      r_waddr_q <= write_addr;
      r_wstop_q <= write_stop_addr;
      r_busy    <= w_busy_next;

      if (w_load_ok && w_waddr_p) r_start <= set_ram_addr;
      if (w_load_ok && w_wstop_p) r_stop  <= stop_addr;

      if (r_wen && (r_count != '1)) r_count <= r_count + CNT_ONE;

      if (w_abort_p) begin
        r_wen <= 1'b0;
      end else if (w_start_cap) begin
        r_ram_addr  <= r_start;
        r_done      <= 1'b0;
        r_wrapped   <= 1'b0;
        r_count     <= '0;
        r_wen       <= 1'b0;
`ifdef CAPTURE_TRIG_EN
        r_last_samp <= r_ch_sync[0];
`endif
      end
`ifdef CAPTURE_TRIG_EN
      else if (r_state == ST_ARMED) begin
        // The trigger sample itself is the first word stored at start.
        if (w_trigger) begin
          r_wen     <= 1'b1;
          r_ram_din <= r_ch_sync;
        end else if (sample_en) begin
          r_last_samp <= r_ch_sync[0];
        end
      end
`endif
      else if (r_state == ST_CAPTURE) begin
        if (w_final) begin
          r_done <= 1'b1;
          r_wen  <= 1'b0;
        end else begin
          if (r_wen) begin
            r_ram_addr <= w_next_addr;
            if (w_at_stop) r_wrapped <= 1'b1;
          end
          r_wen <= sample_en;
          if (sample_en) r_ram_din <= r_ch_sync;
        end
      end
    end
  end

  assign ram_addr     = r_ram_addr;
  assign ram_din      = r_ram_din;
  assign wen          = r_wen;
  assign capture_busy = r_busy;
  assign capture_done = r_done;
  assign wrapped      = r_wrapped;
  assign sample_count = r_count;

endmodule

// File: tb/tb_ch_capture_ctrl.sv
// Bench for ch_capture_ctrl: directed and random capture sessions, a behavioural model that
// predicts every RAM write, and a monitor that pops and compares each write the DUT issues.
module tb_ch_capture_ctrl;
  localparam int N     = 20;
  localparam int DEPTH = 1048576;
  localparam int DW    = 1;

  logic          clk = 1'b0;
  logic          s_axi_reset, sample_en, arm, abort, write_addr, write_stop_addr, loop_capture;
  logic [N-1:0]  set_ram_addr, stop_addr;
  logic [DW-1:0] ch_in;
  logic          trig_pol;
  logic [N-1:0]  ram_addr;
  logic [DW-1:0] ram_din;
  logic          wen, capture_busy, capture_done, wrapped;
  logic [N:0]    sample_count;

  always #5 clk = ~clk;

  ch_capture_ctrl #(.N_ADDR_BITS(N), .MEM_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .s_axi_clk(clk), .s_axi_reset(s_axi_reset), .sample_en(sample_en), .arm(arm),
    .abort(abort), .write_addr(write_addr), .set_ram_addr(set_ram_addr),
    .write_stop_addr(write_stop_addr), .stop_addr(stop_addr), .loop_capture(loop_capture),
    .ch_in(ch_in),
`ifdef CAPTURE_TRIG_EN
    .trig_pol(trig_pol),
`endif
    .ram_addr(ram_addr), .ram_din(ram_din), .wen(wen), .capture_busy(capture_busy),
    .capture_done(capture_done), .wrapped(wrapped), .sample_count(sample_count)
  );

  typedef struct { logic [N-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp  = 0;
  int  n_fail = 0;

  // Reference model of a capture session.
  typedef enum { M_IDLE, M_ARMED, M_CAPTURE, M_DONE } mstate_t;
  mstate_t m_state;
  int      m_start, m_stop, m_addr;
  longint  m_count;
  bit      m_done, m_wrapped, m_loop, m_last;

  function automatic bit m_idle_like();
    return (m_state == M_IDLE) || (m_state == M_DONE);
  endfunction

  function automatic void m_reset();
    m_state = M_IDLE; m_start = 0; m_stop = DEPTH - 1; m_addr = 0;
    m_count = 0; m_done = 0; m_wrapped = 0; m_last = 0;
  endfunction

  function automatic void m_write(bit d);
    wr_t w;
    w.addr = m_addr[N-1:0];
    w.data = d;
    exp_q.push_back(w);
    if (m_count < (64'd1 << (N + 1)) - 1) m_count++;
    if (m_addr == m_stop) begin
      if (m_loop) begin m_addr = m_start; m_wrapped = 1; end
      else begin m_state = M_DONE; m_done = 1; end
    end else begin
      m_addr = (m_addr + 1) % DEPTH;
    end
  endfunction

  function automatic void m_strobe(bit d);
    if (m_state == M_CAPTURE) m_write(d);
    else if (m_state == M_ARMED) begin
      if (d == trig_pol && m_last != trig_pol) begin m_state = M_CAPTURE; m_write(d); end
      else m_last = d;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT asserts wen must match the next predicted write.
  always @(negedge clk) begin
    if (s_axi_reset === 1'b0 && wen === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got write addr %0h data %0h expected none", ram_addr, ram_din);
      end else begin
        mon_e = exp_q.pop_front();
        if (ram_addr !== mon_e.addr || ram_din !== mon_e.data) begin
          n_fail++;
          $display("FAIL wr_compare: got addr %0h data %0h expected addr %0h data %0h",
                   ram_addr, ram_din, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit d);
    ch_in = d;
    tick(3);
    sample_en = 1'b1;
    m_strobe(d);
    tick(1);
    sample_en = 1'b0;
    tick(2);
  endtask

  task automatic burst(input int n, input bit d);
    ch_in = d;
    tick(3);
    sample_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      m_strobe(d);
      tick(1);
    end
    sample_en = 1'b0;
    tick(2);
  endtask

  task automatic load_start(input int a);
    set_ram_addr = a[N-1:0];
    write_addr = 1'b1;
    if (m_idle_like()) m_start = a;
    tick(1);
    write_addr = 1'b0;
    tick(1);
  endtask

  task automatic load_stop(input int a);
    stop_addr = a[N-1:0];
    write_stop_addr = 1'b1;
    if (m_idle_like()) m_stop = a;
    tick(1);
    write_stop_addr = 1'b0;
    tick(1);
  endtask

  task automatic pulse_ctrl(input bit a, input bit b);
    arm = a;
    abort = b;
    if (b) m_state = M_IDLE;
    else if (a && m_idle_like()) begin
      m_addr = m_start; m_done = 0; m_wrapped = 0; m_count = 0; m_last = ch_in[0];
`ifdef CAPTURE_TRIG_EN
      m_state = M_ARMED;
`else
      m_state = M_CAPTURE;
`endif
    end
    tick(1);
    arm = 1'b0;
    abort = 1'b0;
    tick(1);
  endtask

  task automatic set_loop(input bit l);
    loop_capture = l;
    m_loop = l;
  endtask

  task automatic pre_trigger();
`ifdef CAPTURE_TRIG_EN
    strobe(1'b0);
`endif
  endtask

  task automatic check_status(input string tag);
    tick(3);
    check({tag, "_wen"},     wen, 0);
    check({tag, "_addr"},    ram_addr, m_addr);
    check({tag, "_count"},   sample_count, m_count);
    check({tag, "_done"},    capture_done, m_done);
    check({tag, "_wrapped"}, wrapped, m_wrapped);
    check({tag, "_busy"},    capture_busy, (m_state == M_ARMED || m_state == M_CAPTURE));
  endtask

  initial begin
    bit [5:0] loop_pat;
    int start, len;
    s_axi_reset = 1'b1; sample_en = 0; arm = 0; abort = 0; write_addr = 0;
    write_stop_addr = 0; loop_capture = 0; set_ram_addr = '0; stop_addr = '0;
    ch_in = '0; trig_pol = 1'b1; m_loop = 0;
    m_reset();
    tick(2);
    check("rst_wen", wen, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_din", ram_din, 0);
    check("rst_busy", capture_busy, 0);
    check("rst_done", capture_done, 0);
    check("rst_count", sample_count, 0);
    s_axi_reset = 1'b0;
    tick(3);

    // One-shot 0x10..0x13 with data 1,0,1,1.
    set_loop(0); load_start('h10); load_stop('h13); pulse_ctrl(1, 0);
    strobe(1); strobe(0); strobe(1); strobe(1);
    check_status("oneshot");
    check("oneshot_count_4", sample_count, 4);
    check("oneshot_addr_13", ram_addr, 'h13);
    check("oneshot_done_1", capture_done, 1);

    // sample_en held high, 5..9: the strobes after the stop write are dropped.
    load_start(5); load_stop(9); pulse_ctrl(1, 0); pre_trigger();
    burst(8, 1);
    check_status("held");
    check("held_count_5", sample_count, 5);

    // Loop 2..3 with six strobes, then abort.
    loop_pat = 6'b101101;
    set_loop(1); load_start(2); load_stop(3); pulse_ctrl(1, 0); pre_trigger();
    for (int i = 0; i < 6; i++) begin
      strobe(loop_pat[i]);
      if (i == 0) check("loop_wrapped_early", wrapped, 0);
      if (i == 2) check("loop_wrapped_3rd", wrapped, 1);
    end
    check_status("loop");
    pulse_ctrl(0, 1);
    check_status("loop_abort");
    check("loop_abort_done_0", capture_done, 0);

    // Address space wrap: DEPTH-2 .. 1.
    set_loop(0); load_start(DEPTH - 2); load_stop(1); pulse_ctrl(1, 0); pre_trigger();
    for (int i = 0; i < 4; i++) strobe(1'($urandom));
    check_status("memwrap");
    check("memwrap_addr_1", ram_addr, 1);

    // Reset mid-capture restores start=0 and stop=DEPTH-1.
    set_loop(1); load_start(100); load_stop(200); pulse_ctrl(1, 0); pre_trigger();
    strobe(1);
    s_axi_reset = 1'b1;
    tick(1);
    check("midrst_wen", wen, 0);
    check("midrst_addr", ram_addr, 0);
    check("midrst_busy", capture_busy, 0);
    s_axi_reset = 1'b0;
    m_reset();
    tick(3);
    set_loop(0); load_start(DEPTH - 3); pulse_ctrl(1, 0); pre_trigger();
    for (int i = 0; i < 4; i++) strobe(1'($urandom));
    check_status("stop_rst");
    check("stop_rst_addr", ram_addr, DEPTH - 1);

    // Start reload during capture is ignored.
    set_loop(1); load_start(50); load_stop(51); pulse_ctrl(1, 0); pre_trigger();
    strobe(1);
    load_start(70);
    for (int i = 0; i < 3; i++) strobe(1'($urandom));
    check_status("ld_ignored");
    pulse_ctrl(0, 1);

    // Abort beats arm in the same cycle.
    pulse_ctrl(1, 1);
    check_status("abort_arm");

`ifdef CAPTURE_TRIG_EN
    // Rising trigger: 0,0 wait in ARMED, the 1 is stored at start.
    set_loop(0); load_start(300); load_stop(302); pulse_ctrl(1, 0);
    strobe(0);
    check("trig_busy_armed", capture_busy, 1);
    strobe(0);
    check("trig_busy_armed2", capture_busy, 1);
    strobe(1); strobe(0);
    check_status("trig");
    pulse_ctrl(0, 1);
`endif

    // Random sessions.
    for (int s = 0; s < 20; s++) begin
      start = ($urandom_range(0, 3) == 0) ? DEPTH - 1 - int'($urandom_range(0, 2))
                                           : int'($urandom_range(0, DEPTH - 1));
      len = $urandom_range(1, 5);
      set_loop(1'($urandom));
      load_start(start);
      load_stop((start + len - 1) % DEPTH);
      pulse_ctrl(1, 0);
      for (int k = 0, n = $urandom_range(1, len + 3); k < n; k++) begin
        if ($urandom_range(0, 4) == 0) burst($urandom_range(1, 3), 1'($urandom));
        else strobe(1'($urandom));
        if (k == 0 && $urandom_range(0, 1) == 1) begin
          pulse_ctrl(1, 0);
          load_start($urandom_range(0, DEPTH - 1));
        end
      end
      check_status("rnd");
      if (m_state == M_ARMED || m_state == M_CAPTURE) begin
        pulse_ctrl(0, 1);
        check_status("rnd_abort");
      end
    end

    tick(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
